// File: rtl/mmio_console_pkg.sv
// Shared definitions for the MMIO console: decoded addresses, TX state encoding,
// and the write-request bundle seen on the core's data-memory write port.
package mmio_console_pkg;

  localparam logic [31:0] MMIO_PUTC = 32'h8000_0000;
  localparam logic [31:0] MMIO_EXIT = 32'h8000_0004;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } mmio_wr_t;

endpackage

// File: rtl/mmio_console_fifo.sv
// Synchronous byte FIFO. Pointers carry one extra wrap bit, so full/empty fall out
// of a pointer compare. Read data is combinational from the head entry.
module console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             wr_ptr, rd_ptr;
  logic [DEPTH-1:0][7:0]   mem;

  // Pointer update; callers never push when full or pop when empty.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mmio_console.sv
// Console peripheral on the core's write port: decodes PUTC/EXIT, queues bytes,
// serialises them as 8N1 UART, and raises exit only once all output has drained.
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] PUTC_ADDR  = MMIO_PUTC,
  parameter logic [31:0] EXIT_ADDR  = MMIO_EXIT
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        wready,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        hit,
  output logic        wvalid,
  output logic        uart_tx,
  output logic        busy,
  output logic        exit_req,
  output logic [31:0] exit_code
);

  localparam int              BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_DIV - 1);

  mmio_wr_t req;
  logic     is_putc, is_exit;
  logic     putc_push, exit_wr;
  logic     fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic     exit_pending;
  logic     unused_strb;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_last;

  assign req         = '{addr: waddr, data: wdata, strb: wstrb};
  assign unused_strb = ^req.strb[3:1];

  // Address decode and accept handshake. Only a PUTC against a full FIFO stalls;
  // the registered full flag is used, so a pop on this edge does not help.
  assign is_putc   = (req.addr == PUTC_ADDR);
  assign is_exit   = (req.addr == EXIT_ADDR);
  assign hit       = wready && (is_putc || is_exit);
  assign wvalid    = !(wready && is_putc && fifo_full);
  assign putc_push = wready && wvalid && is_putc && req.strb[0] && !exit_req;
  assign exit_wr   = wready && is_exit && !exit_req;

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (putc_push),
    .pop    (fifo_pop),
    .din    (req.data[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Exit: latch code, then raise sticky exit_req once queue and line are idle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      exit_pending <= 1'b0;
      exit_req     <= 1'b0;
      exit_code    <= '0;
    end else begin
      if (exit_wr) begin
        exit_code    <= req.data;
        exit_pending <= 1'b1;
      end
      if (exit_pending && fifo_empty && (state_q == TX_IDLE)) exit_req <= 1'b1;
    end
  end

  // TX state register; uart_tx is a flop so it never glitches and idles high in reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign baud_last = (baud_q == BAUD_LAST);

  // TX next state. The end of STOP pops the next byte directly so frames run back
  // to back; a shifter drains LSB first into tx on each bit boundary.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = TX_START;
          baud_d   = '0;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (baud_last) begin
          state_d = TX_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = TX_START;
            tx_d     = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign uart_tx = tx_q;
  assign busy    = !fifo_empty || (state_q != TX_IDLE);

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console at CLK_DIV=4, FIFO_DEPTH=4. Inputs change away
// from posedge; outputs are sampled on negedges (one sample per clk).
module tb_mmio_console;
  import mmio_console_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        wready = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        hit, wvalid, uart_tx, busy, exit_req;
  logic [31:0] exit_code;

  int n_chk  = 0;
  int n_pass = 0;

  mmio_console #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .wready    (wready),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .hit       (hit),
    .wvalid    (wvalid),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .exit_req  (exit_req),
    .exit_code (exit_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [39:0] exp_frame(input logic [7:0] b);
    logic [9:0]  bits;
    logic [39:0] f;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) f[i] = bits[i / CLK_DIV];
    return f;
  endfunction

  // One write; stall = negedges on which wvalid was seen low before acceptance.
  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int stall);
    stall = 0;
    @(negedge clk);
    wready = 1'b1; waddr = a; wdata = d; wstrb = s;
    #1;
    while (!wvalid && stall < 500) begin
      @(negedge clk); #1;
      stall++;
    end
    if (!wvalid) chk("wr_timeout", 64'(stall), 64'(0));
    @(posedge clk); #1;
    wready = 1'b0;
  endtask

  task automatic wait_start(output int waitc);
    waitc = 0;
    forever begin
      @(negedge clk);
      if (!uart_tx) break;
      waitc++;
      if (waitc > 2000) begin
        chk("rx_timeout", 64'(waitc), 64'(0));
        waitc = -1;
        break;
      end
    end
  endtask

  task automatic rx_frame(output logic [39:0] fr, output int waitc);
    fr = '1;
    wait_start(waitc);
    if (waitc >= 0) begin
      fr[0] = uart_tx;
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        fr[i] = uart_tx;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  logic [39:0] fr, mfr;
  logic [39:0] frs [6];
  int          st  [6];
  int          wcs [6];
  int          stall, wc, mwc, bad;

  initial begin
    // Reset state
    #12;
    chk("rst_tx",   uart_tx,   1'b1);
    chk("rst_busy", busy,      1'b0);
    chk("rst_exit", exit_req,  1'b0);
    chk("rst_code", exit_code, 32'h0);
    @(negedge clk);
    resetb = 1'b1;

    // 1: single PUTC 'A', one-cycle pop latency, exact frame, busy drop
    mmio_wr(MMIO_PUTC, 32'h41, 4'h1, stall);
    chk("t1_stall", 64'(stall), 64'(0));
    rx_frame(fr, wc);
    chk("t1_lat",   64'(wc), 64'(1));
    chk("t1_frame", fr, exp_frame(8'h41));
    chk("t1_busy_last", busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_fall", busy, 1'b0);
    chk("t1_tx_idle", uart_tx, 1'b1);

    // 2: six back-to-back PUTC, sixth stalls until the first STOP->START pop
    fork
      begin
        for (int i = 0; i < 6; i++) mmio_wr(MMIO_PUTC, 32'(8'h61 + i), 4'h1, st[i]);
      end
      begin
        for (int j = 0; j < 6; j++) begin
          rx_frame(mfr, mwc);
          frs[j] = mfr; wcs[j] = mwc;
        end
      end
    join
    for (int i = 0; i < 5; i++) chk($sformatf("t2_stall%0d", i), 64'(st[i]), 64'(0));
    chk("t2_stall_f", 64'(st[5]), 64'(37));
    for (int i = 0; i < 6; i++) chk($sformatf("t2_frame%0d", i), frs[i], exp_frame(8'(8'h61 + i)));
    for (int i = 1; i < 6; i++) chk($sformatf("t2_gap%0d", i), 64'(wcs[i]), 64'(0));

    // 3: three PUTC then EXIT; exit_req one edge after the last STOP ends
    fork
      begin
        mmio_wr(MMIO_PUTC, 32'h78, 4'h1, st[0]);
        mmio_wr(MMIO_PUTC, 32'h79, 4'h1, st[1]);
        mmio_wr(MMIO_PUTC, 32'h7a, 4'h1, st[2]);
        mmio_wr(MMIO_EXIT, 32'h1,  4'hf, st[3]);
        chk("t3_code",     exit_code, 32'h1);
        chk("t3_req_early", exit_req, 1'b0);
      end
      begin
        for (int j = 0; j < 3; j++) begin
          rx_frame(mfr, mwc);
          frs[j] = mfr;
        end
      end
    join
    chk("t3_exit_stall", 64'(st[3]), 64'(0));
    chk("t3_frame2", frs[2], exp_frame(8'h7a));
    chk("t3_req_stop", exit_req, 1'b0);
    @(negedge clk);
    chk("t3_req_idle", exit_req, 1'b0);
    @(negedge clk);
    chk("t3_req_rise", exit_req, 1'b1);
    // after exit, writes are accepted and ignored
    mmio_wr(MMIO_PUTC, 32'h99, 4'h1, stall);
    chk("t3_post_stall", 64'(stall), 64'(0));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || !uart_tx || !exit_req) bad++;
    end
    chk("t3_post_quiet", 64'(bad), 64'(0));

    do_reset();
    #1;
    chk("t3_rst_exit", exit_req,  1'b0);
    chk("t3_rst_code", exit_code, 32'h0);

    // 4: non-hit write, then hit decode for PUTC
    @(negedge clk);
    wready = 1'b1; waddr = 32'h0000_1000; wdata = 32'h41; wstrb = 4'h1;
    #1;
    chk("t4_hit",    hit,    1'b0);
    chk("t4_wvalid", wvalid, 1'b1);
    @(posedge clk); #1;
    wready = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || !uart_tx) bad++;
    end
    chk("t4_quiet", 64'(bad), 64'(0));
    @(negedge clk);
    wready = 1'b1; waddr = MMIO_PUTC; wstrb = 4'h0;
    #1;
    chk("t4_hit_putc", hit, 1'b1);
    wready = 1'b0;
    #1;
    chk("t4_hit_idle", hit, 1'b0);

    // 5: async reset during DATA bit 3, then a clean frame
    mmio_wr(MMIO_PUTC, 32'h55, 4'h1, stall);
    wait_start(wc);
    for (int i = 0; i < 17; i++) @(negedge clk);
    chk("t5_pre_tx", uart_tx, 1'b0);
    #2;
    resetb = 1'b0;
    #1;
    chk("t5_rst_tx",   uart_tx, 1'b1);
    chk("t5_rst_busy", busy,    1'b0);
    @(negedge clk);
    resetb = 1'b1;
    mmio_wr(MMIO_PUTC, 32'h3c, 4'h1, stall);
    rx_frame(fr, wc);
    chk("t5_frame", fr, exp_frame(8'h3c));
    chk("t5_lat",   64'(wc), 64'(1));

    // 6: wstrb without byte 0 is dropped; EXIT accepted with a full FIFO
    repeat (3) @(negedge clk);
    mmio_wr(MMIO_PUTC, 32'h77, 4'b0010, stall);
    chk("t6_drop_stall", 64'(stall), 64'(0));
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || !uart_tx) bad++;
    end
    chk("t6_drop_quiet", 64'(bad), 64'(0));
    for (int i = 0; i < 5; i++) mmio_wr(MMIO_PUTC, 32'(8'h30 + i), 4'h1, st[i]);
    @(negedge clk);
    wready = 1'b1; waddr = MMIO_PUTC; wstrb = 4'h1;
    #1;
    chk("t6_full_stall", wvalid, 1'b0);
    waddr = MMIO_EXIT; wdata = 32'hdead;
    #1;
    chk("t6_exit_wvalid", wvalid, 1'b1);
    @(posedge clk); #1;
    wready = 1'b0;
    chk("t6_code",      exit_code, 32'hdead);
    chk("t6_req_early", exit_req,  1'b0);
    wc = 0;
    while (!exit_req && wc < 400) begin
      @(negedge clk);
      wc++;
    end
    chk("t6_req",  exit_req, 1'b1);
    chk("t6_busy", busy,     1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
